// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and counter sizing shared by ex_muldiv and its step datapath
package muldiv_pkg;
    localparam logic [1:0] MULDIV_MULTU = 2'b00;
    localparam logic [1:0] MULDIV_MULT  = 2'b01;
    localparam logic [1:0] MULDIV_DIVU  = 2'b10;
    localparam logic [1:0] MULDIV_DIV   = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    function automatic int cnt_w(input int w);
        return $clog2(w) + 1;
    endfunction
endpackage

// File: rtl/ex_muldiv_step.sv
// ex_muldiv_step: one combinational shift-add / restoring-divide iteration; divide half only with MULDIV_DIV_EN
module ex_muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
`ifdef MULDIV_DIV_EN
    input  logic               i_div,
`endif
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_opd,
    output logic [2*WIDTH-1:0] o_acc
);
    logic [WIDTH:0]       w_sum;
    logic [2*WIDTH-1:0]   w_mul_acc;

    // multiplier bit sits in acc[0]; partial product accumulates in the upper half and shifts right
    assign w_sum     = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opd} : {(WIDTH+1){1'b0}});
    assign w_mul_acc = {w_sum, i_acc[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
    logic [WIDTH:0]       w_part;
    logic [WIDTH+1:0]     w_diff;
    logic [2*WIDTH-1:0]   w_div_acc;

    // remainder in upper half, dividend bits shift out of the lower half as quotient bits shift in
    assign w_part    = i_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff    = {1'b0, w_part} - {2'b00, i_opd};
    assign w_div_acc = w_diff[WIDTH+1] ? {w_part[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0}
                                       : {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
    assign o_acc     = i_div ? w_div_acc : w_mul_acc;
`else
    assign o_acc     = w_mul_acc;
`endif
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative signed/unsigned multiply/divide for EX; divider compiled in only with MULDIV_DIV_EN
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] opdata1_i,
    input  logic [WIDTH-1:0] opdata2_i,
    input  logic             cancel_i,
    output logic             ready_o,
    output logic             stall_o,
    output logic             done_o,
    output logic             whilo_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             div_by_zero_o
);
    localparam int CW = cnt_w(WIDTH);

    state_t             r_state, w_next, w_div_go;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc, w_acc, w_prod, w_res;
    logic [WIDTH-1:0]   r_opd, r_hi, r_lo, w_mag1, w_mag2;
    logic               r_sign_q, r_dbz, w_signed, w_accept, w_last, w_iter;

    // operands enter the datapath as magnitudes; signs are restored on the final iteration
    assign w_signed = op_i[0];
    assign w_mag1   = (w_signed && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign w_mag2   = (w_signed && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
    assign w_accept = (r_state == S_IDLE) && start_i && !cancel_i;
    assign w_iter   = (r_state == S_MUL) || (r_state == S_DIV);
    assign w_last   = r_cnt == CW'(WIDTH - 1);
    assign w_prod   = r_sign_q ? -w_acc : w_acc;
    assign hi_o     = r_hi;
    assign lo_o     = r_lo;

`ifdef MULDIV_DIV_EN
    logic             r_sign_r;
    logic [WIDTH-1:0] w_quo, w_rem;

    assign w_div_go = (opdata2_i == '0) ? S_DONE : S_DIV;
    assign w_quo    = r_sign_q ? -w_acc[WIDTH-1:0] : w_acc[WIDTH-1:0];
    assign w_rem    = r_sign_r ? -w_acc[2*WIDTH-1:WIDTH] : w_acc[2*WIDTH-1:WIDTH];
    assign w_res    = (r_state == S_DIV) ? {w_rem, w_quo} : w_prod;
`else
    assign w_div_go = S_DONE;
    assign w_res    = w_prod;
`endif

    ex_muldiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULDIV_DIV_EN
        .i_div (r_state == S_DIV),
`endif
        .i_acc (r_acc),
        .i_opd (r_opd),
        .o_acc (w_acc)
    );

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // next state and handshake outputs; cancel overrides every transition
    always_comb begin
        w_next        = r_state;
        ready_o       = r_state == S_IDLE;
        stall_o       = w_accept || w_iter;
        done_o        = r_state == S_DONE;
        whilo_o       = r_state == S_DONE;
        div_by_zero_o = (r_state == S_DONE) && r_dbz;
        case (r_state)
            S_IDLE:  if (start_i) w_next = op_i[1] ? w_div_go : S_MUL;
            S_MUL:   if (w_last) w_next = S_DONE;
            S_DIV:   if (w_last) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
        if (cancel_i) w_next = S_IDLE;
    end

    // datapath: load on accept, iterate, commit fixed-up result on the last iteration
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opd    <= '0;
            r_sign_q <= 1'b0;
            r_dbz    <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
`ifdef MULDIV_DIV_EN
            r_sign_r <= 1'b0;
`endif
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_acc    <= {{WIDTH{1'b0}}, w_mag1};
            r_opd    <= w_mag2;
            r_sign_q <= w_signed & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
            r_dbz    <= 1'b0;
`ifdef MULDIV_DIV_EN
            r_sign_r <= w_signed & opdata1_i[WIDTH-1];
            if (op_i[1] && opdata2_i == '0) begin
                r_hi  <= opdata1_i;
                r_lo  <= '1;
                r_dbz <= 1'b1;
            end
`else
            if (op_i[1]) begin
                r_hi <= '0;
                r_lo <= '0;
            end
`endif
        end else if (w_iter && !cancel_i) begin
            r_cnt <= r_cnt + CW'(1);
            r_acc <= w_acc;
            if (w_last) begin
                r_hi <= w_res[2*WIDTH-1:WIDTH];
                r_lo <= w_res[WIDTH-1:0];
            end
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: directed checks of ex_muldiv (WIDTH=32 and WIDTH=8), divide expectations follow MULDIV_DIV_EN
module tb_ex_muldiv;
`ifdef MULDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b0;
    logic        start_i = 1'b0, cancel_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] a_i = '0, b_i = '0;
    logic        ready_o, stall_o, done_o, whilo_o, dbz_o;
    logic [31:0] hi_o, lo_o;

    logic        s8 = 1'b0, c8 = 1'b0;
    logic [1:0]  op8 = 2'b00;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ready8, stall8, done8, whilo8, dbz8;
    logic [7:0]  hi8, lo8;

    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    ex_muldiv #(.WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .start_i(start_i), .op_i(op_i), .opdata1_i(a_i), .opdata2_i(b_i),
        .cancel_i(cancel_i), .ready_o(ready_o), .stall_o(stall_o), .done_o(done_o), .whilo_o(whilo_o),
        .hi_o(hi_o), .lo_o(lo_o), .div_by_zero_o(dbz_o)
    );

    ex_muldiv #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start_i(s8), .op_i(op8), .opdata1_i(a8), .opdata2_i(b8),
        .cancel_i(c8), .ready_o(ready8), .stall_o(stall8), .done_o(done8), .whilo_o(whilo8),
        .hi_o(hi8), .lo_o(lo8), .div_by_zero_o(dbz8)
    );

    task automatic next_cycle();
        @(posedge clk) #1;
    endtask

    // issue one request in the current (IDLE) cycle and return at the done cycle
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int stalls);
        op_i = op; a_i = a; b_i = b; start_i = 1'b1;
        #1 stalls = int'(stall_o);
        @(posedge clk) #1 start_i = 1'b0;
        lat = 1;
        while (!done_o && lat < 100) begin
            stalls += int'(stall_o);
            next_cycle();
            lat++;
        end
    endtask

    task automatic test_reset();
        #1;
        n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", ready_o); end
        n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL rst_stall: got %b want 0", stall_o); end
        n_vec++; if (done_o !== 1'b0 || whilo_o !== 1'b0 || dbz_o !== 1'b0) begin n_err++; $display("FAIL rst_flags: got done=%b whilo=%b dbz=%b want 000", done_o, whilo_o, dbz_o); end
        n_vec++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin n_err++; $display("FAIL rst_hilo: got %h_%h want 0_0", hi_o, lo_o); end
        repeat (2) next_cycle();
        rst = 1'b1;
        next_cycle();
    endtask

    task automatic test_mult();
        int lat, st;
        do_op(2'b01, 32'hFFFFFFFE, 32'h00000003, lat, st);
        n_vec++; if (lat !== 33) begin n_err++; $display("FAIL mult_lat: got %0d want 33", lat); end
        n_vec++; if (st !== 33) begin n_err++; $display("FAIL mult_stall_cycles: got %0d want 33", st); end
        n_vec++; if (hi_o !== 32'hFFFFFFFF) begin n_err++; $display("FAIL mult_hi: got %h want ffffffff", hi_o); end
        n_vec++; if (lo_o !== 32'hFFFFFFFA) begin n_err++; $display("FAIL mult_lo: got %h want fffffffa", lo_o); end
        n_vec++; if (whilo_o !== 1'b1 || stall_o !== 1'b0 || dbz_o !== 1'b0) begin n_err++; $display("FAIL mult_done_flags: got whilo=%b stall=%b dbz=%b want 100", whilo_o, stall_o, dbz_o); end
        next_cycle();
        n_vec++; if (done_o !== 1'b0 || ready_o !== 1'b1) begin n_err++; $display("FAIL mult_pulse: got done=%b ready=%b want 0 1", done_o, ready_o); end
    endtask

    task automatic test_multu();
        int lat, st;
        do_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, st);
        n_vec++; if (hi_o !== 32'hFFFFFFFE || lo_o !== 32'h00000001) begin n_err++; $display("FAIL multu_result: got %h_%h want fffffffe_00000001", hi_o, lo_o); end
        next_cycle();
    endtask

    task automatic test_div();
        int lat, st;
        do_op(2'b11, 32'hFFFFFFF9, 32'h00000002, lat, st);
        n_vec++; if (lat !== (DIV_EN ? 33 : 1)) begin n_err++; $display("FAIL div_lat: got %0d want %0d", lat, DIV_EN ? 33 : 1); end
        n_vec++; if (lo_o !== (DIV_EN ? 32'hFFFFFFFD : 32'h0) || hi_o !== (DIV_EN ? 32'hFFFFFFFF : 32'h0)) begin n_err++; $display("FAIL div_signed: got hi=%h lo=%h want hi=%h lo=%h", hi_o, lo_o, DIV_EN ? 32'hFFFFFFFF : 32'h0, DIV_EN ? 32'hFFFFFFFD : 32'h0); end
        next_cycle();
        do_op(2'b10, 32'd7, 32'd2, lat, st);
        n_vec++; if (lo_o !== (DIV_EN ? 32'd3 : 32'd0) || hi_o !== (DIV_EN ? 32'd1 : 32'd0)) begin n_err++; $display("FAIL divu_7_2: got hi=%h lo=%h want hi=%h lo=%h", hi_o, lo_o, DIV_EN ? 32'd1 : 32'd0, DIV_EN ? 32'd3 : 32'd0); end
        next_cycle();
        do_op(2'b11, 32'h80000000, 32'hFFFFFFFF, lat, st);
        n_vec++; if (lo_o !== (DIV_EN ? 32'h80000000 : 32'h0) || hi_o !== 32'h0) begin n_err++; $display("FAIL div_overflow: got hi=%h lo=%h want hi=0 lo=%h", hi_o, lo_o, DIV_EN ? 32'h80000000 : 32'h0); end
        next_cycle();
        do_op(2'b10, 32'd5, 32'd0, lat, st);
        n_vec++; if (lat !== 1) begin n_err++; $display("FAIL dbz_lat: got %0d want 1", lat); end
        n_vec++; if (dbz_o !== DIV_EN) begin n_err++; $display("FAIL dbz_flag: got %b want %b", dbz_o, DIV_EN); end
        n_vec++; if (hi_o !== (DIV_EN ? 32'd5 : 32'd0) || lo_o !== (DIV_EN ? 32'hFFFFFFFF : 32'd0)) begin n_err++; $display("FAIL dbz_result: got hi=%h lo=%h want hi=%h lo=%h", hi_o, lo_o, DIV_EN ? 32'd5 : 32'd0, DIV_EN ? 32'hFFFFFFFF : 32'd0); end
        next_cycle();
        n_vec++; if (dbz_o !== 1'b0) begin n_err++; $display("FAIL dbz_pulse: got %b want 0", dbz_o); end
    endtask

    task automatic test_back_to_back();
        int lat, st;
        do_op(2'b00, 32'd6, 32'd7, lat, st);
        n_vec++; if (lo_o !== 32'd42 || hi_o !== 32'd0) begin n_err++; $display("FAIL b2b_first: got %h_%h want 0_0000002a", hi_o, lo_o); end
        next_cycle();
        n_vec++; if (ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b want 1", ready_o); end
        do_op(2'b00, 32'h00010000, 32'h00010000, lat, st);
        n_vec++; if (lat !== 33 || hi_o !== 32'd1 || lo_o !== 32'd0) begin n_err++; $display("FAIL b2b_second: got lat=%0d %h_%h want lat=33 1_0", lat, hi_o, lo_o); end
        next_cycle();
    endtask

    task automatic test_cancel();
        int lat, st;
        logic saw_done;
        do_op(2'b00, 32'd3, 32'd5, lat, st);
        next_cycle();
        op_i = 2'b01; a_i = 32'hFFFFFFFE; b_i = 32'd3; start_i = 1'b1;
        next_cycle();
        start_i = 1'b0;
        saw_done = done_o;
        repeat (9) begin next_cycle(); saw_done |= done_o; end
        cancel_i = 1'b1;
        next_cycle();
        cancel_i = 1'b0;
        n_vec++; if (ready_o !== 1'b1 || done_o !== 1'b0) begin n_err++; $display("FAIL cancel_idle: got ready=%b done=%b want 1 0", ready_o, done_o); end
        n_vec++; if (hi_o !== 32'd0 || lo_o !== 32'd15) begin n_err++; $display("FAIL cancel_hold: got %h_%h want 0_0000000f", hi_o, lo_o); end
        repeat (40) begin next_cycle(); saw_done |= done_o; end
        n_vec++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL cancel_no_done: got %b want 0", saw_done); end
    endtask

    task automatic test_start_cancel();
        op_i = 2'b00; a_i = 32'd2; b_i = 32'd2; start_i = 1'b1; cancel_i = 1'b1;
        #1;
        n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL startcancel_stall: got %b want 0", stall_o); end
        next_cycle();
        start_i = 1'b0; cancel_i = 1'b0;
        #1;
        n_vec++; if (ready_o !== 1'b1 || stall_o !== 1'b0) begin n_err++; $display("FAIL startcancel_accept: got ready=%b stall=%b want 1 0", ready_o, stall_o); end
        next_cycle();
    endtask

    task automatic test_width8();
        int lat;
        op8 = 2'b01; a8 = 8'h80; b8 = 8'h80; s8 = 1'b1;
        next_cycle();
        s8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 50) begin next_cycle(); lat++; end
        n_vec++; if (lat !== 9) begin n_err++; $display("FAIL w8_lat: got %0d want 9", lat); end
        n_vec++; if (hi8 !== 8'h40 || lo8 !== 8'h00) begin n_err++; $display("FAIL w8_result: got %h_%h want 40_00", hi8, lo8); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        op_i = DIV_EN ? 2'b10 : 2'b00; a_i = 32'd7; b_i = 32'd2; start_i = 1'b1;
        next_cycle();
        start_i = 1'b0;
        repeat (4) next_cycle();
        n_vec++; if (stall_o !== 1'b1) begin n_err++; $display("FAIL rstmid_busy: got %b want 1", stall_o); end
        rst = 1'b0;
        #1;
        n_vec++; if (ready_o !== 1'b1 || stall_o !== 1'b0 || done_o !== 1'b0) begin n_err++; $display("FAIL rstmid_ctrl: got ready=%b stall=%b done=%b want 1 0 0", ready_o, stall_o, done_o); end
        n_vec++; if (hi_o !== 32'd0 || lo_o !== 32'd0) begin n_err++; $display("FAIL rstmid_hilo: got %h_%h want 0_0", hi_o, lo_o); end
        next_cycle();
        rst = 1'b1;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_back_to_back();
        test_cancel();
        test_start_cancel();
        test_width8();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
